sbus_mem: RTL and testbench

- S-bus memory responder: the memory-side end of the cache/memory request protocol issued by the MBOX.
- Accepts quadword read and write requests, acknowledges them, and waits a fixed access time.
- Reads: returns the requested words in wrap order. Writes: pulls the requested words in wrap order.
- Used as the backing store in simulation and on FPGA. Requests outside its address range get no response, so the MBOX nonexistent-memory timeout handles them.

---
 rtl/sbus_pkg.sv | 36 +++
 rtl/sbus_mem_array.sv | 16 +
 rtl/sbus_mem.sv | 117 +++++++++++
 tb/tb_sbus_mem.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sbus_pkg.sv
// sbus_pkg: shared types and helpers for the S-bus memory responder.
package sbus_pkg;
  typedef logic [35:0] tW36;
  typedef enum logic [2:0] {IDLE, ACK, WAIT, RDX, WRX} tSbusState;
  typedef struct packed {
    logic [1:0] slot;
    logic       last;
  } tSlot;

  function automatic logic oddPar36(input tW36 w);
    return ~^w;
  endfunction

  // Next requested slot after current in wrap order from start; last when none remain.
  function automatic tSlot nextSlot(input logic [1:0] start, input logic [3:0] rqMask, input logic [1:0] current);
    tSlot r;
    logic [1:0] off, s;
    r.slot = current;
    r.last = 1'b1;
    off = current - start;
    for (int k = 3; k >= 1; k--) begin
      s = start + 2'(k);
      if (2'(k) > off && rqMask[s]) begin
        r.slot = s;
        r.last = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [1:0] firstSlot(input logic [1:0] start, input logic [3:0] rqMask);
    tSlot n;
    n = nextSlot(start, rqMask, start);
    return rqMask[start] ? start : n.slot;
  endfunction
endpackage

// File: rtl/sbus_mem_array.sv
// sbus_mem_array: single-port synchronous RAM, read-first, one-cycle read latency.
module sbus_mem_array #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [35:0]   wdata_i,
  output logic [35:0]   rdata_o
);
  logic [35:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
    rdata_o <= mem[addr_i];
  end
endmodule

// File: rtl/sbus_mem.sv
// sbus_mem: S-bus memory responder serving MBOX quadword read/write requests in wrap order.
module sbus_mem
  import sbus_pkg::*;
#(
  parameter int ADDR_BITS     = 14,
  parameter int ACCESS_CYCLES = 4
) (
  input  logic        clk,
  input  logic        CROBAR,
  input  logic        START,
  input  logic [21:0] ADR,
  input  logic [3:0]  RQ,
  input  logic        RD,
  input  logic        WR,
  input  logic [35:0] dataIn,
  input  logic        dataInPar,
  output logic        ACKN,
  output logic        DATA_VALID,
  output logic [35:0] dataOut,
  output logic        dataOutPar,
  output logic        WR_DATA_RQ,
  output logic        BUSY,
  output logic        PAR_ERR
);
  tSbusState state_q, state_d;
  logic [ADDR_BITS-1:0] adr_q, adr_d, ram_a;
  logic [3:0] rq_q, rq_d, cnt_q, cnt_d;
  logic [1:0] slot_q, slot_d, wslot_q, wslot_d, first, rslot;
  logic wr_q, wr_d, wdone_q, wdone_d, wpend_q, wpend_d, perr_q, perr_d, we, in_range;
  tSlot nx;
  tW36 ram_q;
  assign nx = nextSlot(adr_q[1:0], rq_q, slot_q);
  assign first = firstSlot(adr_q[1:0], rq_q);
  assign in_range = (ADR >> ADDR_BITS) == 22'd0;
  always_comb begin
    state_d = state_q;
    adr_d = adr_q;
    rq_d = rq_q;
    wr_d = wr_q;
    cnt_d = cnt_q;
    slot_d = slot_q;
    wdone_d = wdone_q;
    wpend_d = 1'b0;
    wslot_d = slot_q;
    rslot = nx.slot;
    perr_d = perr_q | (wpend_q & ~(^{dataIn, dataInPar}));
    case (state_q)
      IDLE: if (START && (RD || WR) && in_range) begin
        state_d = ACK;
        adr_d = ADR[ADDR_BITS-1:0];
        rq_d = RQ;
        wr_d = WR;
      end
      ACK: begin
        state_d = (rq_q == 4'd0) ? IDLE : WAIT;
        cnt_d = 4'(ACCESS_CYCLES - 1);
      end
      // The first read address goes out here so RAM latency is hidden.
      WAIT: begin
        rslot = first;
        if (cnt_q == 4'd0) begin
          state_d = wr_q ? WRX : RDX;
          slot_d = first;
          wdone_d = 1'b0;
        end else cnt_d = cnt_q - 4'd1;
      end
      RDX: if (nx.last) state_d = IDLE; else slot_d = nx.slot;
      WRX: if (wdone_q) state_d = IDLE; else begin
        wpend_d = 1'b1;
        wdone_d = nx.last;
        slot_d = nx.slot;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (CROBAR) begin
      state_q <= IDLE;
      adr_q <= '0;
      rq_q <= '0;
      wr_q <= 1'b0;
      cnt_q <= '0;
      slot_q <= '0;
      wdone_q <= 1'b0;
      wpend_q <= 1'b0;
      wslot_q <= '0;
      perr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q <= adr_d;
      rq_q <= rq_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      slot_q <= slot_d;
      wdone_q <= wdone_d;
      wpend_q <= wpend_d;
      wslot_q <= wslot_d;
      perr_q <= perr_d;
    end
  end
  assign ACKN = state_q == ACK;
  assign BUSY = state_q != IDLE;
  assign DATA_VALID = state_q == RDX;
  assign WR_DATA_RQ = state_q == WRX && !wdone_q;
  assign PAR_ERR = perr_q;
  assign we = wpend_q & (^{dataIn, dataInPar}) & ~CROBAR;
  assign ram_a = {adr_q[ADDR_BITS-1:2], we ? wslot_q : rslot};
  assign dataOut = DATA_VALID ? ram_q : '0;
  assign dataOutPar = DATA_VALID & oddPar36(ram_q);
  sbus_mem_array #(.AW(ADDR_BITS)) u_ram (
    .clk(clk),
    .we_i(we),
    .addr_i(ram_a),
    .wdata_i(dataIn),
    .rdata_o(ram_q)
  );
endmodule

// File: tb/tb_sbus_mem.sv
// tb_sbus_mem: scoreboard bench for sbus_mem against a word-array reference model.
module tb_sbus_mem;
  localparam int A = 4;
  typedef struct {
    logic [35:0] d;
    int          t;
  } ev_t;
  logic clk = 0, CROBAR = 1, START = 0, RD = 0, WR = 0, dataInPar = 1;
  logic [21:0] ADR = '0;
  logic [3:0] RQ = '0;
  logic [35:0] dataIn = '0;
  logic ACKN, DATA_VALID, dataOutPar, WR_DATA_RQ, BUSY, PAR_ERR;
  logic [35:0] dataOut;
  int n_chk = 0, n_fail = 0, cyc = 0, exp_idle = 0;
  bit mon_en = 0, perr = 0, any;
  int at[$], wt[$];
  ev_t rq[$], mon_e;
  logic [36:0] wq[$], wv;
  logic [35:0] mem [int];
  logic [35:0] wdat [4];

  sbus_mem #(.ADDR_BITS(14), .ACCESS_CYCLES(A)) dut (
    .clk(clk), .CROBAR(CROBAR), .START(START), .ADR(ADR), .RQ(RQ), .RD(RD), .WR(WR),
    .dataIn(dataIn), .dataInPar(dataInPar), .ACKN(ACKN), .DATA_VALID(DATA_VALID),
    .dataOut(dataOut), .dataOutPar(dataOutPar), .WR_DATA_RQ(WR_DATA_RQ), .BUSY(BUSY),
    .PAR_ERR(PAR_ERR)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Issues one request; when tracked, the model predicts every response cycle and word.
  task automatic req(input logic [21:0] a, input logic [3:0] m, input logic rd, input logic wr,
                     input logic [3:0] bad, input bit track);
    int n = 0;
    int key, s;
    logic [35:0] d;
    START = 1; ADR = a; RQ = m; RD = rd; WR = wr;
    if (track) begin
      at.push_back(cyc + 1);
      for (int k = 0; k < 4; k++) begin
        s = (int'(a[1:0]) + k) % 4;
        if (m[s]) begin
          key = int'(a[13:2]) * 4 + s;
          if (wr) begin
            d = wdat[n];
            wq.push_back({bad[s] ? ^d : ~^d, d});
            wt.push_back(cyc + 2 + A + n);
            if (bad[s]) perr = 1; else mem[key] = d;
          end else rq.push_back('{mem[key], cyc + 2 + A + n});
          n++;
        end
      end
      exp_idle = (m == 0) ? cyc + 2 : cyc + 2 + A + n + (wr ? 1 : 0);
    end
    @(posedge clk); #1;
    START = 0; RD = 0; WR = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!BUSY) break;
    end
    chk("idle_cycle", 64'(cyc), 64'(exp_idle));
    @(posedge clk); #1;
  endtask

  task automatic rnd_wdat();
    for (int i = 0; i < 4; i++) wdat[i] = {4'($urandom), 32'($urandom)};
  endtask

  always @(negedge clk) if (mon_en) begin
    if (ACKN) begin
      if (at.size() == 0) chk("ackn_unexpected", 1, 0);
      else chk("ackn_cycle", 64'(cyc), 64'(at.pop_front()));
    end
    if (DATA_VALID) begin
      if (rq.size() == 0) chk("dv_unexpected", 1, 0);
      else begin
        mon_e = rq.pop_front();
        chk("rd_data", 64'(dataOut), 64'(mon_e.d));
        chk("rd_par", 64'(dataOutPar), 64'(~^mon_e.d));
        chk("rd_cycle", 64'(cyc), 64'(mon_e.t));
      end
    end else chk("dout_idle_zero", {27'd0, dataOutPar, dataOut}, 0);
    if (WR_DATA_RQ) begin
      if (wt.size() == 0) chk("wrq_unexpected", 1, 0);
      else chk("wrq_cycle", 64'(cyc), 64'(wt.pop_front()));
    end
  end

  initial forever begin
    @(negedge clk);
    if (mon_en && WR_DATA_RQ && wq.size() > 0) begin
      wv = wq.pop_front();
      @(posedge clk); #1;
      dataIn = wv[35:0];
      dataInPar = wv[36];
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {ACKN, DATA_VALID, dataOut, dataOutPar, WR_DATA_RQ, BUSY, PAR_ERR}, 0);
    CROBAR = 0;
    mon_en = 1;
    @(posedge clk); #1;
    wdat = '{36'h111111111, 36'h222222222, 36'h333333333, 36'h444444444};
    req(22'h000010, 4'b1111, 0, 1, 4'b0, 1);
    wait_idle();
    req(22'h000010, 4'b1111, 1, 0, 4'b0, 1);
    wait_idle();
    req(22'h000012, 4'b1011, 1, 0, 4'b0, 1);
    wait_idle();
    req(22'h010000, 4'b1111, 1, 0, 4'b0, 0);
    any = 0;
    repeat (20) begin
      @(negedge clk);
      any |= ACKN | BUSY;
    end
    chk("out_of_range_silent", 64'(any), 0);
    @(posedge clk); #1;
    req(22'h000011, 4'b0110, 1, 0, 4'b0, 1);
    repeat (2) @(posedge clk);
    #1;
    rnd_wdat();
    req(22'h000014, 4'b1111, 0, 1, 4'b0, 0);
    wait_idle();
    rnd_wdat();
    req(22'h000010, 4'b0100, 0, 1, 4'b0100, 1);
    wait_idle();
    chk("par_err_set", 64'(PAR_ERR), 64'(perr));
    req(22'h000010, 4'b0100, 1, 0, 4'b0, 1);
    wait_idle();
    chk("par_err_hold", 64'(PAR_ERR), 64'(perr));
    req(22'h000013, 4'b0000, 1, 0, 4'b0, 1);
    wait_idle();
    rnd_wdat();
    req(22'h000021, 4'b1101, 1, 1, 4'b0, 1);
    wait_idle();
    req(22'h000021, 4'b1101, 1, 0, 4'b0, 1);
    wait_idle();
    req(22'h000010, 4'b1111, 1, 0, 4'b0, 1);
    repeat (6) @(posedge clk);
    #1;
    CROBAR = 1;
    @(posedge clk); #1;
    CROBAR = 0;
    chk("reset_mid_read", {ACKN, DATA_VALID, dataOut, dataOutPar, WR_DATA_RQ, BUSY, PAR_ERR}, 0);
    rq.delete();
    perr = 0;
    repeat (2) @(posedge clk);
    #1;
    req(22'h000010, 4'b1001, 1, 0, 4'b0, 1);
    wait_idle();
    for (int q = 0; q < 8; q++) begin
      rnd_wdat();
      req(22'(q * 4), 4'b1111, 0, 1, 4'b0, 1);
      wait_idle();
    end
    for (int i = 0; i < 40; i++) begin
      logic wr;
      logic [21:0] a;
      wr = 1'($urandom);
      a = 22'($urandom_range(0, 31));
      rnd_wdat();
      req(a, 4'($urandom), ~wr | 1'($urandom), wr,
          (wr && $urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0, 1);
      wait_idle();
      chk("par_err_model", 64'(PAR_ERR), 64'(perr));
    end
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(at.size() + rq.size() + wt.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
